stop_watch_bcd: RTL

- Parametrised BCD stopwatch; successor to the fixed 1-minute-digit StopWatch.
- Adds the following over the current block:
  - configurable clock prescaler and number of minute digits;
  - explicit run/pause state machine with a synchronous clear;
  - wrap or saturate at full scale, with an overflow flag;
  - optional lap capture.
- Drives the display digit decoders directly.

---
 rtl/stop_watch_bcd.sv | 166 ++++++++++++++++
 1 files changed

// File: rtl/stop_watch_bcd.sv
// BCD stopwatch: tenths, seconds, MIN_DIGITS minute digits with IDLE/RUN/PAUSE control.
// Lap capture registers exist only when STOPWATCH_LAP_EN is defined.
module stop_watch_bcd #(
   parameter int CLK_DIV    = 4,
   parameter int MIN_DIGITS = 1,
   parameter bit WRAP       = 1'b1
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic                    start_resume,
   input  logic                    stop,
   input  logic                    clear,
   input  logic                    lap,
   output logic [4*MIN_DIGITS-1:0] min,
   output logic [3:0]              sec1,
   output logic [3:0]              sec0,
   output logic [3:0]              milSec0,
   output logic                    running,
   output logic                    overflow,
   output logic [4*MIN_DIGITS-1:0] lap_min,
   output logic [3:0]              lap_sec1,
   output logic [3:0]              lap_sec0,
   output logic [3:0]              lap_milSec0,
   output logic                    lap_valid
);
   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_RUN   = 2'd1;
   localparam logic [1:0] S_PAUSE = 2'd2;
   localparam int PW = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
   localparam logic [PW-1:0] PMAX = PW'(CLK_DIV - 1);

   logic [1:0]              state_q, state_d;
   logic [PW-1:0]           presc_q, presc_d;
   logic [4*MIN_DIGITS-1:0] min_q, min_d;
   logic [3:0]              s1_q, s1_d, s0_q, s0_d, ms_q, ms_d;
   logic                    ovf_q, ovf_d;
   logic                    tick, full, cy;

   assign tick = (state_q == S_RUN) && (presc_q == PMAX);

   always_comb begin
      full = (s1_q == 4'd5) && (s0_q == 4'd9) && (ms_q == 4'd9);
      for (int k = 0; k < MIN_DIGITS; k++)
         if (min_q[4*k +: 4] != 4'd9) full = 1'b0;
   end

   always_comb begin
      state_d = state_q;
      presc_d = presc_q;
      min_d   = min_q;
      s1_d    = s1_q;
      s0_d    = s0_q;
      ms_d    = ms_q;
      ovf_d   = WRAP ? 1'b0 : ovf_q;
      cy      = 1'b0;
      case (state_q)
         S_RUN: begin
            presc_d = tick ? '0 : presc_q + PW'(1);
            if (tick && full) begin
               ovf_d = 1'b1;
               if (WRAP) begin
                  min_d = '0; s1_d = '0; s0_d = '0; ms_d = '0;
               end
            end else if (tick) begin
               // Ripple the carry through every digit in one cycle; full scale is excluded above.
               cy = 1'b1;
               if (ms_q == 4'd9) ms_d = '0;
               else begin ms_d = ms_q + 4'd1; cy = 1'b0; end
               if (cy) begin
                  if (s0_q == 4'd9) s0_d = '0;
                  else begin s0_d = s0_q + 4'd1; cy = 1'b0; end
               end
               if (cy) begin
                  if (s1_q == 4'd5) s1_d = '0;
                  else begin s1_d = s1_q + 4'd1; cy = 1'b0; end
               end
               for (int k = 0; k < MIN_DIGITS; k++) begin
                  if (cy) begin
                     if (min_q[4*k +: 4] == 4'd9) min_d[4*k +: 4] = '0;
                     else begin min_d[4*k +: 4] = min_q[4*k +: 4] + 4'd1; cy = 1'b0; end
                  end
               end
            end
            if (stop || (tick && full && !WRAP)) state_d = S_PAUSE;
         end
         default: begin
            if (clear) begin
               state_d = S_IDLE;
               presc_d = '0;
               min_d   = '0; s1_d = '0; s0_d = '0; ms_d = '0;
               ovf_d   = 1'b0;
            end else if (start_resume && !stop && !ovf_q) begin
               state_d = S_RUN;
            end
         end
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= S_IDLE;
         presc_q <= '0;
         min_q   <= '0;
         s1_q    <= '0;
         s0_q    <= '0;
         ms_q    <= '0;
         ovf_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         presc_q <= presc_d;
         min_q   <= min_d;
         s1_q    <= s1_d;
         s0_q    <= s0_d;
         ms_q    <= ms_d;
         ovf_q   <= ovf_d;
      end
   end

   assign min      = min_q;
   assign sec1     = s1_q;
   assign sec0     = s0_q;
   assign milSec0  = ms_q;
   assign running  = (state_q == S_RUN);
   assign overflow = ovf_q;

`ifdef STOPWATCH_LAP_EN
   logic [4*MIN_DIGITS-1:0] lap_min_q;
   logic [3:0]              lap_s1_q, lap_s0_q, lap_ms_q;
   logic                    lap_v_q;

   // Captures the pre-edge digits, so a tick on the same edge is not included.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         lap_min_q <= '0;
         lap_s1_q  <= '0;
         lap_s0_q  <= '0;
         lap_ms_q  <= '0;
         lap_v_q   <= 1'b0;
      end else if (state_q == S_RUN) begin
         if (lap) begin
            lap_min_q <= min_q;
            lap_s1_q  <= s1_q;
            lap_s0_q  <= s0_q;
            lap_ms_q  <= ms_q;
            lap_v_q   <= 1'b1;
         end
      end else if (clear) begin
         lap_v_q <= 1'b0;
      end
   end

   assign lap_min     = lap_min_q;
   assign lap_sec1    = lap_s1_q;
   assign lap_sec0    = lap_s0_q;
   assign lap_milSec0 = lap_ms_q;
   assign lap_valid   = lap_v_q;
`else
   logic unused_lap;
   assign unused_lap  = lap;
   assign lap_min     = '0;
   assign lap_sec1    = '0;
   assign lap_sec0    = '0;
   assign lap_milSec0 = '0;
   assign lap_valid   = 1'b0;
`endif
endmodule
